// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/loader arbiter for a single-port data memory with lane steering and load extension
module dmem_arbiter #(
    parameter int AW   = 7,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [1:0]      c_size,
    input  logic            c_unsigned,
    input  logic [XLEN-1:0] c_addr,
    input  logic [XLEN-1:0] c_wdata,
    output logic            c_gnt,
    output logic            c_rvalid,
    output logic [XLEN-1:0] c_rdata,
    output logic            c_err,
    input  logic            l_req,
    input  logic            l_we,
    input  logic            l_lock,
    input  logic [AW-1:0]   l_addr,
    input  logic [XLEN-1:0] l_wdata,
    output logic            l_gnt,
    output logic            l_rvalid,
    output logic [XLEN-1:0] l_rdata,
    output logic            m_we,
    output logic [3:0]      m_amp,
    output logic [AW-1:0]   m_ad,
    output logic [XLEN-1:0] m_wd,
    input  logic [XLEN-1:0] m_rd
);
    typedef enum logic {ARB, LOCK} state_t;
    state_t state, state_nx;
    logic last_ldr;
    logic mis;
    logic [1:0] off;
    logic [3:0] mask;
    logic [7:0] b;
    logic [15:0] h;
    logic [XLEN-1:0] ext;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ARB;
            last_ldr <= 1'b1;
        end else begin
            state    <= state_nx;
            last_ldr <= c_gnt ? 1'b0 : l_gnt ? 1'b1 : last_ldr;
        end
    end

    // Lock is released as soon as the loader drops l_lock, granted or idle
    always_comb begin
        state_nx = state == ARB ? ((l_gnt && l_lock) ? LOCK : ARB) : (l_lock ? LOCK : ARB);
    end

    always_comb begin
        c_gnt = state == ARB && c_req && (!l_req || last_ldr);
        l_gnt = state == LOCK ? l_req : l_req && (!c_req || !last_ldr);
    end

    always_comb begin
        off  = c_addr[1:0];
        mis  = c_size == 2'b11 || (c_size == 2'b01 && off[0]) || (c_size == 2'b10 && off != 2'b00);
        mask = c_size == 2'b00 ? 4'b0001 << off : c_size == 2'b01 ? 4'b0011 << off : 4'b1111;
        m_we = l_gnt ? l_we : c_gnt && c_we && !mis;
        m_amp = l_gnt ? 4'b1111 : (c_gnt && !mis) ? mask : 4'b0000;
        m_ad = l_gnt ? l_addr : c_gnt ? c_addr[AW+1:2] : '0;
        m_wd = l_gnt ? l_wdata : !c_gnt ? '0 :
               c_size == 2'b00 ? {4{c_wdata[7:0]}} :
               c_size == 2'b01 ? {2{c_wdata[15:0]}} : c_wdata;
        b    = m_rd[{off, 3'b000} +: 8];
        h    = m_rd[{off[1], 4'b0000} +: 16];
        ext  = c_size == 2'b00 ? {{24{b[7] & ~c_unsigned}}, b} :
               c_size == 2'b01 ? {{16{h[15] & ~c_unsigned}}, h} : m_rd;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            c_rvalid <= 1'b0;
            c_err    <= 1'b0;
            c_rdata  <= '0;
            l_rvalid <= 1'b0;
            l_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt;
            c_err    <= c_gnt && mis;
            if (c_gnt) c_rdata <= mis ? '0 : ext;
            l_rvalid <= l_gnt;
            if (l_gnt && !l_we) l_rdata <= m_rd;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, locking, lane steering and load extension
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        c_req, c_we, c_unsigned;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    logic        c_gnt, c_rvalid, c_err;
    logic [31:0] c_rdata;
    logic        l_req, l_we, l_lock;
    logic [6:0]  l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        m_we;
    logic [3:0]  m_amp;
    logic [6:0]  m_ad;
    logic [31:0] m_wd, m_rd;
    logic [31:0] mem [128] = '{default: 32'h0};
    int vec = 0;
    int errs = 0;

    dmem_arbiter #(.AW(7), .XLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .c_rdata(c_rdata), .c_err(c_err),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_we(m_we), .m_amp(m_amp), .m_ad(m_ad), .m_wd(m_wd), .m_rd(m_rd)
    );

    always #5 clk = ~clk;

    assign m_rd = mem[m_ad];
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (m_we && m_amp[i]) mem[m_ad][8*i +: 8] <= m_wd[8*i +: 8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        c_req = 1'b1; c_we = we; c_size = size; c_unsigned = uns;
        c_addr = addr; c_wdata = wdata;
    endtask

    initial begin
        rstn = 1'b0;
        c_req = 0; c_we = 0; c_size = 2'b10; c_unsigned = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
        step; step;
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_c_err", c_err, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_l_rdata", l_rdata, 0);
        chk("idle_m_amp", m_amp, 0);
        chk("idle_m_we", m_we, 0);

        rstn = 1'b1;
        cpu(1, 2'b10, 0, 32'h08, 32'hDEADBEEF);
        #1;
        chk("sw_gnt", c_gnt, 1);
        chk("sw_m_ad", m_ad, 2);
        chk("sw_m_amp", m_amp, 4'b1111);
        chk("sw_m_we", m_we, 1);
        chk("sw_m_wd", m_wd, 32'hDEADBEEF);
        step;
        chk("sw_rvalid", c_rvalid, 1);
        chk("sw_err", c_err, 0);

        cpu(0, 2'b10, 0, 32'h08, 0);
        #1;
        chk("lw_gnt", c_gnt, 1);
        chk("lw_m_we", m_we, 0);
        step;
        chk("lw_rvalid", c_rvalid, 1);
        chk("lw_rdata", c_rdata, 32'hDEADBEEF);
        chk("lw_err", c_err, 0);

        cpu(1, 2'b00, 0, 32'h0B, 32'h80);
        #1;
        chk("sb_m_amp", m_amp, 4'b1000);
        chk("sb_m_wd", m_wd, 32'h80808080);
        chk("sb_m_we", m_we, 1);
        step;
        cpu(0, 2'b00, 0, 32'h0B, 0);
        step;
        chk("lb_rdata", c_rdata, 32'hFFFFFF80);
        cpu(0, 2'b00, 1, 32'h0B, 0);
        step;
        chk("lbu_rdata", c_rdata, 32'h00000080);
        cpu(0, 2'b01, 0, 32'h0A, 0);
        step;
        chk("lh_rdata", c_rdata, 32'hFFFF80AD);
        cpu(0, 2'b01, 1, 32'h0A, 0);
        step;
        chk("lhu_rdata", c_rdata, 32'h000080AD);

        cpu(1, 2'b01, 0, 32'h03, 32'h1234);
        #1;
        chk("mis_gnt", c_gnt, 1);
        chk("mis_m_we", m_we, 0);
        chk("mis_m_amp", m_amp, 0);
        step;
        chk("mis_rvalid", c_rvalid, 1);
        chk("mis_err", c_err, 1);
        chk("mis_rdata", c_rdata, 0);
        chk("mis_mem", mem[0], 0);
        c_req = 0;
        step;
        chk("idle_rvalid", c_rvalid, 0);
        chk("idle_err", c_err, 0);

        rstn = 1'b0;
        step;
        rstn = 1'b1;
        cpu(0, 2'b10, 0, 32'h0, 0);
        l_req = 1; l_we = 0; l_lock = 0; l_addr = 7'd2;
        #1;
        chk("rr1_c", c_gnt, 1);
        chk("rr1_l", l_gnt, 0);
        step;
        chk("rr1_rvalid", c_rvalid, 1);
        chk("rr2_c", c_gnt, 0);
        chk("rr2_l", l_gnt, 1);
        step;
        chk("rr2_l_rvalid", l_rvalid, 1);
        chk("rr2_l_rdata", l_rdata, 32'h80ADBEEF);
        chk("rr3_c", c_gnt, 1);
        chk("rr3_l", l_gnt, 0);
        step;
        chk("rr4_c", c_gnt, 0);
        chk("rr4_l", l_gnt, 1);
        step;

        c_req = 0;
        l_req = 1; l_we = 1; l_lock = 1; l_addr = 7'd5; l_wdata = 32'h11111111;
        #1;
        chk("lk1_l", l_gnt, 1);
        chk("lk1_m_amp", m_amp, 4'b1111);
        step;
        c_req = 1;
        #1;
        chk("lk2_c", c_gnt, 0);
        chk("lk2_l", l_gnt, 1);
        step;
        l_lock = 0;
        #1;
        chk("lk3_c", c_gnt, 0);
        chk("lk3_l", l_gnt, 1);
        step;
        chk("lk_mem5", mem[5], 32'h11111111);
        chk("lk_l_rvalid", l_rvalid, 1);
        l_we = 0;
        #1;
        chk("lk4_c", c_gnt, 1);
        chk("lk4_l", l_gnt, 0);
        step;

        c_req = 0; l_lock = 1;
        #1;
        chk("rl1_l", l_gnt, 1);
        step;
        c_req = 1; rstn = 0;
        #1;
        chk("rl2_c", c_gnt, 0);
        step;
        chk("rl_c_rvalid", c_rvalid, 0);
        chk("rl_l_rvalid", l_rvalid, 0);
        rstn = 1; l_lock = 0;
        #1;
        chk("rl3_c", c_gnt, 1);
        chk("rl3_l", l_gnt, 0);
        step;
        chk("rl3_c_rvalid", c_rvalid, 1);
        chk("rl3_l_rvalid", l_rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store port and a word-wide loader port (UART/debug program loader).
- Arbitrates between them round-robin, with a loader lock for bursts.
- Converts CPU size and byte offset into a byte-lane mask and lane-replicated write data.
- Extracts and sign/zero-extends CPU load data, flags misaligned CPU accesses, and returns registered responses one cycle after acceptance.

Parameters:
- AW, 7, word-address width of the memory (128 words).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous reset, active-low.
- c_req  in  1  CPU request.
- c_we  in  1  CPU write (1 = store, 0 = load).
- c_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
- c_unsigned  in  1  load zero-extend (lbu/lhu).
- c_addr  in  XLEN  CPU byte address; bits [AW+1:2] select the word, bits [1:0] are the offset, upper bits are ignored.
- c_wdata  in  XLEN  CPU store data, right-justified.
- c_gnt  out  1  CPU request accepted this cycle.
- c_rvalid  out  1  CPU response valid.
- c_rdata  out  XLEN  extended load data.
- c_err  out  1  misaligned or illegal access; valid with c_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader write; always a full word.
- l_lock  in  1  hold ownership after the current grant.
- l_addr  in  AW  loader word address.
- l_wdata  in  XLEN  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader response valid.
- l_rdata  out  XLEN  raw word read.
- m_we  out  1  memory write enable.
- m_amp  out  4  memory byte-lane mask.
- m_ad  out  AW  memory word address.
- m_wd  out  XLEN  lane-replicated write data.
- m_rd  in  XLEN  memory read data, combinational from m_ad.

Behaviour:
- Reset (rstn=0 at an edge): state ARB, last_owner=LOADER (CPU wins the first tie). c_rvalid, l_rvalid, c_err = 0; c_rdata, l_rdata = 0.
- Grants are combinational from the request lines and state. A transaction is accepted when req and gnt are both high. A write takes effect at that clock edge.
- When neither port is granted: m_we=0, m_amp=0, m_ad=0, m_wd=0.
- State ARB:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port that is not last_owner.
  - last_owner updates on every grant.
  - Loader granted with l_lock=1: go to LOCK.
- State LOCK:
  - c_gnt=0 always.
  - l_gnt=l_req.
  - Return to ARB at the first edge where l_gnt=1 and l_lock=0, or where l_req=0 and l_lock=0.
- Reset asserted in LOCK: return to ARB; no response pulses in the following cycle.
- Latency: response registers load at the accepting edge, so rvalid is high in the next cycle for exactly one cycle, for both loads and stores. Back-to-back accepts give back-to-back rvalid.
- CPU lane mapping, with off = c_addr[1:0]:
  - byte: amp = 0001 << off; m_wd = byte replicated x4.
  - half: amp = 0011 << off; m_wd = halfword replicated x2.
  - word: amp = 1111; m_wd = c_wdata.
- CPU misalignment: half with off[0]=1, word with off!=0, or size=11.
  - Still granted, but m_we=0 and m_amp=0.
  - Next cycle: c_rvalid=1, c_err=1, c_rdata=0.
- CPU load data: select the byte/half at off from m_rd, then sign-extend, or zero-extend if c_unsigned. A word load is returned unmodified.
- Loader path: m_amp=1111, m_ad=l_addr, m_wd=l_wdata, m_we=l_we. l_rdata captures m_rd on a loader read; it holds its value on a write.
- Address mapping: m_ad = c_addr[AW+1:2] for the CPU; upper address bits wrap silently.
- Simultaneous requests in the same cycle never both see gnt=1.

Test Plan:
- CPU sw addr=0x08, data=0xDEADBEEF -> m_ad=2, m_amp=1111, m_we=1; then lw 0x08 -> c_rdata=0xDEADBEEF one cycle after c_gnt, c_err=0.
- CPU sb 0x0B data=0x80, then lb 0x0B -> m_amp=1000, m_wd=0x80808080; c_rdata=0xFFFFFF80. lbu 0x0B -> 0x00000080.
- CPU sh 0x03 (misaligned) -> c_gnt=1, m_we=0; next cycle c_rvalid=1, c_err=1; memory unchanged.
- c_req and l_req held high for 4 cycles after reset -> grants alternate CPU, LDR, CPU, LDR.
- Loader writes 0x11111111 to word 5 with l_lock=1 for 3 grants while c_req is high -> c_gnt=0 throughout; CPU granted in the cycle after the l_lock=0 grant.
- rstn=0 during LOCK with both requesting -> next cycle state ARB, CPU granted first, c_rvalid/l_rvalid=0 in the cycle after reset.
